mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the pipelined CPU's instruction-fetch port and its MEM-stage data port.
//  Serialises requests and sequences the memory handshake through a 4-state FSM.
//  Returns per-port ready pulses, which the pipeline turns into IF/MEM stall signals.
//  Sits between the CPU core and the memory model at SoC top level.
// PARAMETERS
//  AW           32   address width (byte address)
//  DW           32   data width
//  MAX_D_STREAK 4    consecutive data grants allowed while a fetch waits (>=1)
//  TIMEOUT_CYC  255  BUSY cycles without mem_ack before abort (used only with MEMARB_TIMEOUT_EN)
// PORTS
//  clk       in   1   clock
//  reset     in   1   synchronous, active-high reset
//  if_req    in   1   fetch request; held with if_addr until if_ready
//  if_addr   in   AW  fetch address
//  if_rdata  out  DW  fetched instruction; valid while if_ready=1, held afterwards
//  if_ready  out  1   one-cycle completion pulse, fetch port
//  d_req     in   1   data request; held with d_we/d_addr/d_wdata/d_ctrl until d_ready
//  d_we      in   1   1 = store, 0 = load
//  d_addr    in   AW  data address
//  d_wdata   in   DW  store data
//  d_ctrl    in   3   dm_ctrl size/sign code, passed through to memory unchanged
//  d_rdata   out  DW  load data; valid while d_ready=1, held afterwards
//  d_ready   out  1   one-cycle completion pulse, data port
//  mem_req   out  1   memory request, registered
//  mem_we    out  1   registered copy of the granted d_we (0 for fetch)
//  mem_addr  out  AW  registered granted address
//  mem_wdata out  DW  registered store data
//  mem_ctrl  out  3   registered granted ctrl (fetch uses word code)
//  mem_ack   in   1   memory done; sampled only while mem_req=1
//  mem_rdata in   DW  read data, valid in the mem_ack cycle
//  arb_err   out  1   one-cycle timeout-abort pulse, coincident with the ready pulse
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; rdata registers 0; state IDLE; streak counter 0.
//  Reset mid-transaction:
//   - next edge returns to IDLE and drops mem_req; the pending access gets no ready pulse.
//  States:
//   - IDLE: arbitrate. Neither request: stay in IDLE.
//     Grant data if d_req & (!if_req | streak<MAX_D_STREAK); otherwise grant fetch if if_req.
//     Register the winner's command onto mem_*; mem_req=1 next cycle; go to BUSY.
//   - BUSY: mem_req=1, mem_* stable. On mem_ack, capture mem_rdata into the winner's rdata register; go to RESP.
//     mem_ack may arrive in the first BUSY cycle.
//   - RESP: mem_req=0; winner's ready=1 for exactly this cycle; no arbitration; go to IDLE.
//  Timing:
//   - minimum latency: req seen in IDLE at cycle 0, mem_ack at cycle 1, ready at cycle 2, next grant at cycle 3.
//   - peak throughput: 1 access per 3 cycles.
//  Streak counter (saturating):
//   - +1 on each data grant made while if_req=1.
//   - cleared on fetch grant, or when a data grant is made with if_req=0.
//  Simultaneous requests:
//   - data wins (older instruction) until the streak reaches MAX_D_STREAK; fetch is then guaranteed the next grant.
//  Stores:
//   - d_ready pulses; d_rdata is not updated.
//  Spurious inputs:
//   - mem_ack outside BUSY is ignored.
//   - request deasserted before ready is a protocol violation; the access still completes.
//  Arbitration sees only IDLE-cycle inputs:
//   - the pipeline flush does not cancel an in-flight access; it must discard that ready.
// CONFIGURATION
//  MEMARB_TIMEOUT_EN defined:
//   - BUSY counter counts cycles since entering BUSY.
//   - reaching TIMEOUT_CYC without mem_ack drops mem_req and goes to RESP.
//   - winner's rdata is 0, ready=1, arb_err=1 in that cycle.
//   - counter clears on every BUSY entry.
//  MEMARB_TIMEOUT_EN undefined:
//   - no counter; BUSY waits indefinitely; arb_err tied 0.
// STRUCTURE
//  State encodings ST_IDLE/ST_BUSY/ST_RESP and grant codes GNT_IF/GNT_D go in a shared `define header, arb_encode_def.v,
//   beside ctrl_encode_def.v; fetch ctrl code reuses the word dm_ctrl define.
//  One sub-module, mem_arb_timer: loadable down-counter with an expire flag, instantiated only under MEMARB_TIMEOUT_EN.
// TESTING
//  1. Reset held 3 cycles mid-BUSY -> mem_req=0 after the edge, no ready pulse, all outputs 0.
//  2. Fetch only, addr 0x0000_0040, mem_ack in first BUSY cycle, rdata 0x0000_0013
//     -> if_ready at cycle 2 with if_rdata=0x0000_0013; mem_we=0.
//  3. Store d_addr 0x100, d_wdata 0xDEAD_BEEF, d_ctrl 3'b000, ack after 2 wait cycles
//     -> mem_we=1, mem_wdata=0xDEAD_BEEF, d_ready at cycle 4; d_rdata unchanged.
//  4. if_req and d_req both held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I...
//  5. if_req and d_req rise together in IDLE, streak 0 -> data granted first; fetch granted in the following IDLE.
//  6. With MEMARB_TIMEOUT_EN, TIMEOUT_CYC=8, no mem_ack -> ready pulse, arb_err=1 and rdata=0 nine cycles after grant.
//     Without the macro -> arbiter stays in BUSY.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// Optional feature macro: MEMARB_TIMEOUT_EN (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntIf = 1'b0,
    GntD  = 1'b1
  } arb_gnt_e;

  localparam int unsigned CtrlW = 3;

  // dm_ctrl word-access code; fetches always use it
  localparam logic [CtrlW-1:0] DmWord = 3'b000;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter with an expire flag; bounds how long BUSY may wait for mem_ack.
// Instantiated by mem_port_arbiter only when MEMARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-ported memory (IDLE/BUSY/RESP).
// Define MEMARB_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYC BUSY cycles without mem_ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic [DW-1:0]    if_rdata,
  output logic             if_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  input  logic [CtrlW-1:0] d_ctrl,
  output logic [DW-1:0]    d_rdata,
  output logic             d_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic [CtrlW-1:0] mem_ctrl,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata,
  output logic             arb_err
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  arb_state_e       state_q, state_d;
  arb_gnt_e         gnt_q;
  logic [SW-1:0]    streak_q;
  logic             grant_data, grant_fetch, timeout_hit;
  logic             mem_req_q, mem_we_q, arb_err_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q, if_rdata_q, d_rdata_q;
  logic [CtrlW-1:0] mem_ctrl_q;

`ifdef MEMARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic timer_expired;

  // Reloaded every IDLE cycle so each BUSY entry starts a fresh window
  mem_arb_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == StIdle),
    .load_val (TW'(TIMEOUT_CYC - 1)),
    .dec      (state_q == StBusy),
    .expired  (timer_expired)
  );

  assign timeout_hit = (state_q == StBusy) && timer_expired && !mem_ack;
`else
  assign timeout_hit = 1'b0;
`endif

  // Data is the older instruction; the streak limit keeps fetch from starving
  always_comb begin
    grant_data  = d_req && (!if_req || (32'(streak_q) < MAX_D_STREAK));
    grant_fetch = if_req && !grant_data;
    state_d     = state_q;
    case (state_q)
      StIdle:  if (grant_data || grant_fetch) state_d = StBusy;
      StBusy:  if (mem_ack || timeout_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      gnt_q       <= GntIf;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ctrl_q  <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      arb_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          arb_err_q <= 1'b0;
          if (grant_data) begin
            gnt_q       <= GntD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_ctrl_q  <= d_ctrl;
            if (!if_req) begin
              streak_q <= '0;
            end else if (32'(streak_q) < MAX_D_STREAK) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (grant_fetch) begin
            gnt_q       <= GntIf;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_ctrl_q  <= DmWord;
            streak_q    <= '0;
          end
        end
        StBusy: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (gnt_q == GntIf) begin
              if_rdata_q <= mem_rdata;
            end else if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            arb_err_q <= 1'b1;
            if (gnt_q == GntIf) begin
              if_rdata_q <= '0;
            end else begin
              d_rdata_q <= '0;
            end
          end
        end
        default: arb_err_q <= 1'b0;
      endcase
    end
  end

  assign if_ready  = (state_q == StResp) && (gnt_q == GntIf);
  assign d_ready   = (state_q == StResp) && (gnt_q == GntD);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign arb_err   = arb_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store/load, streak fairness, timeout.
// Build with MEMARB_TIMEOUT_EN defined to exercise the timeout-abort path.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ctrl;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .AW           (32),
    .DW           (32),
    .MAX_D_STREAK (4),
    .TIMEOUT_CYC  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ctrl    (d_ctrl),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ctrl  (mem_ctrl),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .arb_err   (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the active edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_ctrl = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick; tick; tick;
    total++;
    if ({mem_req, mem_we, if_ready, d_ready, arb_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000", {mem_req, mem_we, if_ready, d_ready, arb_err});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_ctrl} !== 67'b0) begin
      bad++;
      $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata, mem_ctrl});
    end
    total++;
    if ({if_rdata, d_rdata} !== 64'b0) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata});
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick;  // cycle 1: BUSY
    total++;
    if ({mem_req, mem_we, mem_addr, mem_ctrl} !== {1'b1, 1'b0, 32'h0000_0040, 3'b000}) begin
      bad++;
      $display("FAIL fetch_cmd: got req=%b we=%b addr=%h ctrl=%b want 1 0 00000040 000",
               mem_req, mem_we, mem_addr, mem_ctrl);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick;  // cycle 2: RESP
    total++;
    if ({if_ready, d_ready, mem_req, if_rdata} !== {3'b100, 32'h0000_0013}) begin
      bad++;
      $display("FAIL fetch_resp: got ir=%b dr=%b req=%b rdata=%h want 1 0 0 00000013",
               if_ready, d_ready, mem_req, if_rdata);
    end
    mem_ack = 1'b0; if_req = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    tick;  // cycle 3: IDLE
    total++;
    if ({if_ready, if_rdata} !== {1'b0, 32'h0000_0013}) begin
      bad++;
      $display("FAIL fetch_hold: got ready=%b rdata=%h want 0 00000013", if_ready, if_rdata);
    end
  endtask

  task automatic test_store;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_ctrl = 3'b000;
    tick;  // cycle 1
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h0000_0100, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL store_cmd: got req=%b we=%b addr=%h wdata=%h want 1 1 00000100 deadbeef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    tick;  // cycle 2, wait
    tick;  // cycle 3, wait
    total++;
    if ({mem_req, d_ready} !== 2'b10) begin
      bad++;
      $display("FAIL store_wait: got req=%b ready=%b want 1 0", mem_req, d_ready);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick;  // cycle 4: RESP
    total++;
    if ({d_ready, if_ready, d_rdata} !== {2'b10, 32'h0}) begin
      bad++;
      $display("FAIL store_resp: got dr=%b ir=%b d_rdata=%h want 1 0 00000000",
               d_ready, if_ready, d_rdata);
    end
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick;
  endtask

  task automatic test_load;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_ctrl = 3'b010;
    tick;
    total++;
    if ({mem_we, mem_ctrl, mem_addr} !== {1'b0, 3'b010, 32'h0000_0200}) begin
      bad++;
      $display("FAIL load_cmd: got we=%b ctrl=%b addr=%h want 0 010 00000200",
               mem_we, mem_ctrl, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick;
    total++;
    if ({d_ready, d_rdata, if_rdata} !== {1'b1, 32'hCAFE_F00D, 32'h0000_0013}) begin
      bad++;
      $display("FAIL load_resp: got ready=%b d_rdata=%h if_rdata=%h want 1 cafef00d 00000013",
               d_ready, d_rdata, if_rdata);
    end
    mem_ack = 1'b0; d_req = 1'b0;
    tick;
  endtask

  task automatic test_streak;
    logic exp_d;
    if_addr = 32'h0000_1000; d_addr = 32'h0000_2000; d_we = 1'b0; d_ctrl = 3'b010;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_d = ((i % 5) != 4);
      tick;  // BUSY
      total++;
      if (mem_addr !== (exp_d ? 32'h0000_2000 : 32'h0000_1000)) begin
        bad++;
        $display("FAIL streak_grant%0d: got addr=%h want %h", i, mem_addr,
                 exp_d ? 32'h0000_2000 : 32'h0000_1000);
      end
      mem_ack = 1'b1; mem_rdata = 32'hA5A5_0000 + i;
      tick;  // RESP
      total++;
      if ({if_ready, d_ready} !== (exp_d ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL streak_ready%0d: got ir/dr=%b want %b", i, {if_ready, d_ready},
                 exp_d ? 2'b01 : 2'b10);
      end
      mem_ack = 1'b0;
      tick;  // IDLE
    end
    if_req = 1'b0; d_req = 1'b0;
    total++;
    if ({if_rdata, d_rdata} !== {32'hA5A5_0009, 32'hA5A5_0008}) begin
      bad++;
      $display("FAIL streak_rdata: got if=%h d=%h want a5a50009 a5a50008", if_rdata, d_rdata);
    end
  endtask

  task automatic test_simultaneous;
    if_addr = 32'h0000_3000; d_addr = 32'h0000_4000; if_req = 1'b1; d_req = 1'b1;
    tick;
    total++;
    if (mem_addr !== 32'h0000_4000) begin
      bad++;
      $display("FAIL simul_first: got addr=%h want 00004000", mem_addr);
    end
    mem_ack = 1'b1;
    tick;
    d_req = 1'b0; mem_ack = 1'b0;
    tick;  // IDLE, fetch still waiting
    tick;
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_3000}) begin
      bad++;
      $display("FAIL simul_second: got req=%b addr=%h want 1 00003000", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    tick;
    total++;
    if (if_ready !== 1'b1) begin
      bad++;
      $display("FAIL simul_ready: got %b want 1", if_ready);
    end
    if_req = 1'b0; mem_ack = 1'b0;
    tick;
  endtask

  task automatic test_spurious_ack;
    mem_ack = 1'b1;
    tick; tick;
    total++;
    if ({mem_req, if_ready, d_ready} !== 3'b000) begin
      bad++;
      $display("FAIL spurious_ack: got req/ir/dr=%b want 000", {mem_req, if_ready, d_ready});
    end
    mem_ack = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_busy;
    if_req = 1'b1; if_addr = 32'h0000_0060;
    tick;
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy: got req=%b want 1", mem_req);
    end
    reset = 1'b1;
    tick;
    total++;
    if ({mem_req, if_ready} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_drop: got req/ready=%b want 00", {mem_req, if_ready});
    end
    mem_ack = 1'b1;
    tick; tick;
    reset = 1'b0; if_req = 1'b0; mem_ack = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, if_rdata, d_rdata, arb_err} !== 134'b0)
    begin
      bad++;
      $display("FAIL midrst_outs: got addr=%h if_rdata=%h d_rdata=%h req=%b want all 0",
               mem_addr, if_rdata, d_rdata, mem_req);
    end
    tick;
    total++;
    if ({if_ready, d_ready} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_noready: got %b want 00", {if_ready, d_ready});
    end
  endtask

  task automatic test_timeout;
    if_req = 1'b1; if_addr = 32'h0000_0050; mem_rdata = 32'h7777_7777;
    tick;  // cycle 1
`ifdef MEMARB_TIMEOUT_EN
    for (int c = 1; c < 9; c++) begin
      total++;
      if ({mem_req, if_ready, arb_err} !== 3'b100) begin
        bad++;
        $display("FAIL timeout_wait%0d: got req/ready/err=%b want 100", c,
                 {mem_req, if_ready, arb_err});
      end
      tick;
    end
    total++;
    if ({if_ready, arb_err, mem_req, if_rdata} !== {3'b110, 32'h0}) begin
      bad++;
      $display("FAIL timeout_abort: got ready=%b err=%b req=%b rdata=%h want 1 1 0 0",
               if_ready, arb_err, mem_req, if_rdata);
    end
    if_req = 1'b0;
    tick;
    total++;
    if ({if_ready, arb_err} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_after: got ready/err=%b want 00", {if_ready, arb_err});
    end
`else
    for (int c = 1; c < 21; c++) begin
      total++;
      if ({mem_req, if_ready, d_ready, arb_err} !== 4'b1000) begin
        bad++;
        $display("FAIL busy_hold%0d: got req/ir/dr/err=%b want 1000", c,
                 {mem_req, if_ready, d_ready, arb_err});
      end
      tick;
    end
    reset = 1'b1; if_req = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL busy_recover: got req=%b want 0", mem_req);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store;
    test_load;
    test_streak;
    test_simultaneous;
    test_spurious_ack;
    test_reset_mid_busy;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
